serial_frame_receiver: RTL
==========================

// Module: serial_frame_receiver
// PURPOSE
//  Downstream consumer of the 4-bit shift register's shift_out. Deframes the
//  delayed serial stream, one bit per CLK, into parallel words.
//  Checks parity and stop bit, then presents each word on a valid/ready port.
//  Sits between the shift-register delay line and the parallel datapath.
// PARAMETERS
//  DATA_W     8  data bits per frame, sent LSB first
//  PARITY_EN  1  1: a parity bit follows the data; 0: no parity bit
//  PARITY_ODD 0  0: even parity; 1: odd parity (ignored when PARITY_EN=0)
// PORTS
//  CLK         in   1       clock; all logic on posedge
//  Reset       in   1       synchronous, active-high reset
//  serial_in   in   1       serial bit; wired to shift-register shift_out
//  data_out    out  DATA_W  received word; stable while data_valid=1
//  data_valid  out  1       word available; held until accepted
//  data_ready  in   1       consumer accepts word when data_valid&data_ready
//  parity_err  out  1       parity of the held word was wrong; valid with data_valid
//  frame_err   out  1       one-cycle pulse: stop bit bad, frame discarded
//  overrun     out  1       sticky: a good frame was dropped; cleared only by Reset
//  busy        out  1       1 when the FSM is not in IDLE
// BEHAVIOUR
//  Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0,
//   overrun=0, busy=0, FSM=IDLE. Reset mid-frame aborts the frame.
//  Line idle level is 0, matching the upstream register's reset value.
//  Frame format: start=1, DATA_W data bits (LSB first), optional parity bit,
//   stop=0.
//  FSM states and transitions:
//   - IDLE: serial_in=1 -> DATA, with bit count cleared. Otherwise stay in IDLE.
//   - DATA: shift in one bit per cycle. After DATA_W bits -> PARITY if
//     PARITY_EN=1, else -> STOP.
//   - PARITY: sample the parity bit, compare with the computed parity -> STOP.
//   - STOP: always return to IDLE. The next start bit is sampled no earlier
//     than the following cycle.
//  Timing: start bit sampled at edge E0, data at E1..E_DATA_W, parity at
//   E_DATA_W+1, stop at the last edge. data_valid rises after the stop edge.
//   Frame length is DATA_W+2+PARITY_EN cycles.
//  Stop bit = 1: discard the frame and pulse frame_err for one cycle.
//   data_out, data_valid and overrun are unchanged.
//  Good stop bit, delivery rules:
//   - Output slot empty, or accepted in this same cycle: load data_out and
//     parity_err, set data_valid=1.
//   - Output slot still held (data_valid=1, data_ready=0): drop the new word,
//     set overrun=1, keep the held word.
//  A frame with a parity error is still delivered, with parity_err=1.
//  Accept without a new frame: data_valid=0 on the next cycle; data_out holds.
//  data_ready while data_valid=0 has no effect.
// TESTING
//  T1 DATA_W=8, even parity: send 1,10100101,0,0 (0xA5).
//     -> after the stop edge: data_out=A5, valid=1, parity_err=0.
//  T2 Same frame with parity bit=1 -> data_out=A5, parity_err=1, frame_err=0.
//  T3 Frame for 0x3C with stop=1 -> frame_err pulses 1 cycle; data_valid stays 0.
//  T4 Hold data_ready=0, send 0x11 then 0x22 back-to-back.
//     -> data_out=11, overrun=1. Raise ready -> valid falls, overrun stays 1.
//  T5 Ready high during the stop edge of 0x22 while 0x11 is held.
//     -> 0x11 is accepted, 0x22 is loaded, valid stays 1, overrun=0.
//  T6 Assert Reset at data bit 4 of a frame.
//     -> all outputs go to 0 and FSM=IDLE. The next full frame 0x5A is
//        received correctly.

Source files
------------

// File: rtl/serial_frame_receiver_if.sv
// Purpose : Bundles the serial input and the parallel valid/ready output of
//           serial_frame_receiver into one interface.
// Signals :
//   serial_in   serial bit stream from the shift-register delay line
//   data_out    received word, stable while data_valid=1
//   data_valid  word available, held until accepted
//   data_ready  consumer accepts the word when data_valid & data_ready
//   parity_err  parity of the held word was wrong, valid with data_valid
//   frame_err   one-cycle pulse when a frame was discarded for a bad stop bit
//   overrun     sticky flag: a good frame was dropped because the slot was full
//   busy        receiver is inside a frame
// Modports:
//   slave  - the receiver
//   master - the producer/consumer side (serial source and word consumer)
interface serial_frame_receiver_if #(
    parameter int DATA_W = 8
);
    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport slave (
        input  serial_in,
        input  data_ready,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output overrun,
        output busy
    );

    modport master (
        output serial_in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Purpose : Deframes the delayed serial stream coming out of the 4-bit shift
//           register, one bit per CLK, into parallel words. Frame format is
//           start=1, DATA_W data bits LSB first, optional parity bit, stop=0.
//           The line idles at 0. Good frames are presented on a valid/ready
//           port; frames with a bad stop bit are discarded with a frame_err
//           pulse.
// Ports   :
//   CLK    clock, all logic on posedge
//   Reset  synchronous, active-high reset; aborts any frame in progress
//   rx     serial_frame_receiver_if.slave (serial_in, data_ready in;
//          data_out, data_valid, parity_err, frame_err, overrun, busy out)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a start bit (serial_in=1)
// DATA   | shifting in DATA_W data bits, LSB first
// PARITY | sampling the parity bit and recording the parity check result
// STOP   | sampling the stop bit, delivering or discarding the word
module serial_frame_receiver #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                     CLK,
    input  logic                     Reset,
    serial_frame_receiver_if.slave   rx
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_err_r;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            par_err_r     <= 1'b0;
            rx.data_out   <= '0;
            rx.data_valid <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.overrun    <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            rx.frame_err <= 1'b0;

            // Consumer handshake; a delivery in STOP below overrides this.
            if (rx.data_valid && rx.data_ready)
                rx.data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx.serial_in) begin
                        state     <= DATA;
                        bit_cnt   <= CNT_LOAD;
                        par_err_r <= 1'b0;
                        rx.busy   <= 1'b1;
                    end
                end

                DATA: begin
                    // LSB arrives first, so shift in from the top.
                    shift_reg <= {rx.serial_in, shift_reg[DATA_W-1:1]};
                    if (bit_cnt == '0)
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                    else
                        bit_cnt <= bit_cnt - 1'b1;
                end

                PARITY: begin
                    // XOR of data plus parity bit is 0 for even, 1 for odd.
                    par_err_r <= ((^shift_reg) ^ rx.serial_in) != 1'(PARITY_ODD);
                    state     <= STOP;
                end

                STOP: begin
                    state   <= IDLE;
                    rx.busy <= 1'b0;
                    if (rx.serial_in) begin
                        rx.frame_err <= 1'b1;
                    end else if (!rx.data_valid || rx.data_ready) begin
                        rx.data_out   <= shift_reg;
                        rx.parity_err <= par_err_r;
                        rx.data_valid <= 1'b1;
                    end else begin
                        rx.overrun <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    rx.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
